// File: rtl/chi5_link_ctrl_pkg.sv
// Shared types and constants for the multi-lane CHI link-activation controller.
//   tx_st_t / rx_st_t : per-direction link-activation states
//   lane_state_t      : {tx, rx} state pair reported per lane
//   CRD_W             : width of the per-lane TX credit count
package chi5_link_ctrl_pkg;

  localparam int unsigned CRD_W = 4;
  localparam int unsigned LS_W  = 4;

  typedef enum logic [1:0] {TxStop, TxAct, TxRun, TxDeact} tx_st_t;
  typedef enum logic [1:0] {RxStop, RxAct, RxRun, RxDeact} rx_st_t;

  typedef struct packed {
    tx_st_t tx;
    rx_st_t rx;
  } lane_state_t;

endpackage

// File: rtl/chi5_link_ctrl_if.sv
// Bundle of the per-lane link-activation, credit and status signals.
//   master : protocol layer / physical link side (drives requests, acks, credits)
//   slave  : chi5_link_ctrl (drives activation outputs, credit pulses, status)
interface chi5_link_ctrl_if
  import chi5_link_ctrl_pkg::*;
#(
  parameter int unsigned NUM_LINKS = 2
);

  logic [NUM_LINKS-1:0]       tx_up_req;
  logic [NUM_LINKS-1:0]       txlinkactiveack;
  logic [NUM_LINKS-1:0]       txlinkactivereq;
  logic [NUM_LINKS-1:0]       tx_lcrdv;
  logic [NUM_LINKS-1:0]       tx_crd_use;
  logic [NUM_LINKS-1:0]       tx_crd_return;
  logic [NUM_LINKS*CRD_W-1:0] tx_crd_cnt;
  logic [NUM_LINKS-1:0]       rxlinkactivereq;
  logic [NUM_LINKS-1:0]       rxlinkactiveack;
  logic [NUM_LINKS-1:0]       rx_ready;
  logic [NUM_LINKS-1:0]       rx_flit_vld;
  logic [NUM_LINKS-1:0]       rx_lcrdv;
  logic [NUM_LINKS*LS_W-1:0]  link_states;
  logic [NUM_LINKS-1:0]       link_up;
  logic [NUM_LINKS-1:0]       err_timeout;
  logic [NUM_LINKS-1:0]       err_crd;

  modport master (
    output tx_up_req, txlinkactiveack, tx_lcrdv, tx_crd_use,
           rxlinkactivereq, rx_ready, rx_flit_vld,
    input  txlinkactivereq, tx_crd_return, tx_crd_cnt, rxlinkactiveack,
           rx_lcrdv, link_states, link_up, err_timeout, err_crd
  );

  modport slave (
    input  tx_up_req, txlinkactiveack, tx_lcrdv, tx_crd_use,
           rxlinkactivereq, rx_ready, rx_flit_vld,
    output txlinkactivereq, tx_crd_return, tx_crd_cnt, rxlinkactiveack,
           rx_lcrdv, link_states, link_up, err_timeout, err_crd
  );

endinterface

// File: rtl/chi5_link_lane.sv
// One link lane: TX and RX activation FSMs, TX credit counter, RX outstanding
// grant counter and TX handshake timeout. All outputs are decoded from
// registered state.
//   ACLK/ARESETn : clock, synchronous active-low reset
//   tx_*         : TX activation handshake and credit interface
//   rx_*         : RX activation handshake and credit interface
//   link_state   : {tx, rx} state, link_up, sticky err_timeout / err_crd
module chi5_link_lane
  import chi5_link_ctrl_pkg::*;
#(
  parameter int unsigned TX_CRD_MAX     = 15,
  parameter int unsigned RX_CRD_MAX     = 15,
  parameter int unsigned TIMEOUT_CYCLES = 1024
) (
  input  logic             ACLK,
  input  logic             ARESETn,
  input  logic             tx_up_req,
  input  logic             txlinkactiveack,
  input  logic             tx_lcrdv,
  input  logic             tx_crd_use,
  output logic             txlinkactivereq,
  output logic             tx_crd_return,
  output logic [CRD_W-1:0] tx_crd_cnt,
  input  logic             rxlinkactivereq,
  input  logic             rx_ready,
  input  logic             rx_flit_vld,
  output logic             rxlinkactiveack,
  output logic             rx_lcrdv,
  output lane_state_t      link_state,
  output logic             link_up,
  output logic             err_timeout,
  output logic             err_crd
);

  localparam int unsigned RX_W  = $clog2(RX_CRD_MAX + 1);
  localparam int unsigned TMO_W = $clog2(TIMEOUT_CYCLES + 1);

  tx_st_t           tx_q,   tx_d;
  rx_st_t           rx_q,   rx_d;
  logic [CRD_W-1:0] txc_q,  txc_d;
  logic [RX_W-1:0]  rxo_q,  rxo_d;
  logic [TMO_W-1:0] tmo_q,  tmo_d;
  logic             errt_q, errt_d;
  logic             errc_q, errc_d;
  logic             tx_inc, tx_dec, tx_ret, rx_grant, rx_take;

  // State and counter registers.
  always_ff @(posedge ACLK) begin
    if (!ARESETn) begin
      tx_q   <= TxStop;
      rx_q   <= RxStop;
      txc_q  <= '0;
      rxo_q  <= '0;
      tmo_q  <= '0;
      errt_q <= 1'b0;
      errc_q <= 1'b0;
    end else begin
      tx_q   <= tx_d;
      rx_q   <= rx_d;
      txc_q  <= txc_d;
      rxo_q  <= rxo_d;
      tmo_q  <= tmo_d;
      errt_q <= errt_d;
      errc_q <= errc_d;
    end
  end

  // Next-state, credit and timeout logic.
  always_comb begin
    tx_d   = tx_q;
    rx_d   = rx_q;
    tmo_d  = tmo_q;
    errt_d = errt_q;

    case (tx_q)
      TxStop:  if (tx_up_req && !txlinkactiveack) tx_d = TxAct;
      TxAct:   if (txlinkactiveack) tx_d = TxRun;
      TxRun:   if (!tx_up_req) tx_d = TxDeact;
      TxDeact: if (!txlinkactiveack && (txc_q == '0)) tx_d = TxStop;
      default: tx_d = TxStop;
    endcase

    // RxAct always advances on rx_ready, even if the request has dropped.
    case (rx_q)
      RxStop:  if (rxlinkactivereq) rx_d = RxAct;
      RxAct:   if (rx_ready) rx_d = RxRun;
      RxRun:   if (!rxlinkactivereq) rx_d = RxDeact;
      RxDeact: if (rxo_q == '0) rx_d = RxStop;
      default: rx_d = RxStop;
    endcase

    // TX credits: any illegal event is flagged and leaves the count alone.
    tx_inc = tx_lcrdv && ((tx_q == TxAct) || (tx_q == TxRun)) &&
             (txc_q != CRD_W'(TX_CRD_MAX));
    tx_dec = tx_crd_use && (tx_q == TxRun) && (txc_q != '0);
    tx_ret = (tx_q == TxDeact) && (txc_q != '0);
    txc_d  = txc_q + CRD_W'(tx_inc) - CRD_W'(tx_dec) - CRD_W'(tx_ret);

    // RX credits: grant while below the limit, each flit returns one.
    rx_grant = (rx_q == RxRun) && (rxo_q < RX_W'(RX_CRD_MAX));
    rx_take  = rx_flit_vld && (rxo_q != '0);
    rxo_d    = rxo_q + RX_W'(rx_grant) - RX_W'(rx_take);

    errc_d = errc_q | (tx_lcrdv && !tx_inc) | (tx_crd_use && !tx_dec) |
             (rx_flit_vld && !rx_take);

    // Timeout counts handshake-pending cycles and saturates at the limit.
    if ((tx_q == TxAct) || (tx_q == TxDeact)) begin
      if (tmo_q != TMO_W'(TIMEOUT_CYCLES)) tmo_d = tmo_q + TMO_W'(1);
      if (tmo_q == TMO_W'(TIMEOUT_CYCLES - 1)) errt_d = 1'b1;
    end else begin
      tmo_d = '0;
    end
  end

  assign txlinkactivereq = (tx_q == TxAct) || (tx_q == TxRun);
  assign tx_crd_return   = tx_ret;
  assign tx_crd_cnt      = txc_q;
  assign rxlinkactiveack = (rx_q == RxRun) || (rx_q == RxDeact);
  assign rx_lcrdv        = rx_grant;
  assign link_state      = '{tx: tx_q, rx: rx_q};
  assign link_up         = (tx_q == TxRun) && (rx_q == RxRun);
  assign err_timeout     = errt_q;
  assign err_crd         = errc_q;

endmodule

// File: rtl/chi5_link_ctrl.sv
// Multi-lane CHI link-activation controller: NUM_LINKS independent lanes,
// each with TX/RX activation FSMs, L-credit tracking and a timeout monitor.
//   ACLK/ARESETn : clock, synchronous active-low reset
//   bus          : per-lane handshake, credit and status vectors (slave side)
module chi5_link_ctrl
  import chi5_link_ctrl_pkg::*;
#(
  parameter int unsigned NUM_LINKS      = 2,
  parameter int unsigned TX_CRD_MAX     = 15,
  parameter int unsigned RX_CRD_MAX     = 15,
  parameter int unsigned TIMEOUT_CYCLES = 1024
) (
  input logic            ACLK,
  input logic            ARESETn,
  chi5_link_ctrl_if.slave bus
);

  logic [NUM_LINKS-1:0]       txreq, txret, rxack, rxgnt, up, errt, errc;
  logic [NUM_LINKS*CRD_W-1:0] cnt;
  logic [NUM_LINKS*LS_W-1:0]  st;
  lane_state_t                lane_st [NUM_LINKS];

  // One lane instance per link; lanes share nothing but the clock and reset.
  for (genvar i = 0; i < NUM_LINKS; i++) begin : g_lane
    chi5_link_lane #(
      .TX_CRD_MAX     (TX_CRD_MAX),
      .RX_CRD_MAX     (RX_CRD_MAX),
      .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_lane (
      .ACLK            (ACLK),
      .ARESETn         (ARESETn),
      .tx_up_req       (bus.tx_up_req[i]),
      .txlinkactiveack (bus.txlinkactiveack[i]),
      .tx_lcrdv        (bus.tx_lcrdv[i]),
      .tx_crd_use      (bus.tx_crd_use[i]),
      .txlinkactivereq (txreq[i]),
      .tx_crd_return   (txret[i]),
      .tx_crd_cnt      (cnt[i*CRD_W +: CRD_W]),
      .rxlinkactivereq (bus.rxlinkactivereq[i]),
      .rx_ready        (bus.rx_ready[i]),
      .rx_flit_vld     (bus.rx_flit_vld[i]),
      .rxlinkactiveack (rxack[i]),
      .rx_lcrdv        (rxgnt[i]),
      .link_state      (lane_st[i]),
      .link_up         (up[i]),
      .err_timeout     (errt[i]),
      .err_crd         (errc[i])
    );
    assign st[i*LS_W +: LS_W] = lane_st[i];
  end

  assign bus.txlinkactivereq = txreq;
  assign bus.tx_crd_return   = txret;
  assign bus.tx_crd_cnt      = cnt;
  assign bus.rxlinkactiveack = rxack;
  assign bus.rx_lcrdv        = rxgnt;
  assign bus.link_states     = st;
  assign bus.link_up         = up;
  assign bus.err_timeout     = errt;
  assign bus.err_crd         = errc;

endmodule

// File: tb/tb_chi5_link_ctrl.sv
// Directed bench for chi5_link_ctrl: two lanes, 15 credits, 8-cycle timeout.
module tb_chi5_link_ctrl;
  import chi5_link_ctrl_pkg::*;

  logic ACLK = 1'b0;
  logic ARESETn;
  int   n_vec = 0;
  int   n_err = 0;
  int   pulses;

  chi5_link_ctrl_if #(.NUM_LINKS(2)) bus ();

  chi5_link_ctrl #(
    .NUM_LINKS      (2),
    .TX_CRD_MAX     (15),
    .RX_CRD_MAX     (15),
    .TIMEOUT_CYCLES (8)
  ) dut (
    .ACLK    (ACLK),
    .ARESETn (ARESETn),
    .bus     (bus)
  );

  always #5 ACLK = ~ACLK;

  task automatic check_eq(input string tag, input logic [31:0] got,
                          input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Advance n clocks; inputs change and outputs are sampled 1ns after the edge.
  task automatic tick(input int n = 1);
    repeat (n) @(posedge ACLK);
    #1;
  endtask

  initial begin
    ARESETn              = 1'b0;
    bus.tx_up_req        = '0;
    bus.txlinkactiveack  = '0;
    bus.tx_lcrdv         = '0;
    bus.tx_crd_use       = '0;
    bus.rxlinkactivereq  = '0;
    bus.rx_ready         = '0;
    bus.rx_flit_vld      = '0;
    tick(2);
    ARESETn = 1'b1;

    check_eq("rst_states",  32'(bus.link_states),     32'h0);
    check_eq("rst_txreq",   32'(bus.txlinkactivereq), 32'h0);
    check_eq("rst_rxack",   32'(bus.rxlinkactiveack), 32'h0);
    check_eq("rst_txcnt",   32'(bus.tx_crd_cnt),      32'h0);
    check_eq("rst_rxlcrdv", 32'(bus.rx_lcrdv),        32'h0);
    check_eq("rst_errs",    32'({bus.err_timeout, bus.err_crd}), 32'h0);

    // Flit on lane 1 with nothing outstanding is a credit error.
    bus.rx_flit_vld = 2'b10;
    tick();
    bus.rx_flit_vld = 2'b00;
    check_eq("rx_flit_err", 32'(bus.err_crd), 32'h2);

    // Lane 0 TX bring-up.
    bus.tx_up_req = 2'b01;
    tick();
    check_eq("tx_act",      32'(bus.link_states[3:2]),  32'(TxAct));
    check_eq("tx_req_act",  32'(bus.txlinkactivereq),   32'h1);
    tick();
    bus.txlinkactiveack = 2'b01;
    tick();
    check_eq("tx_run",      32'(bus.link_states[3:2]),  32'(TxRun));

    // Lane 0 RX bring-up.
    bus.rxlinkactivereq = 2'b01;
    bus.rx_ready        = 2'b01;
    tick();
    check_eq("rx_act",      32'(bus.link_states[1:0]),  32'(RxAct));
    check_eq("rx_ack_act",  32'(bus.rxlinkactiveack),   32'h0);
    tick();
    check_eq("rx_run",      32'(bus.link_states[1:0]),  32'(RxRun));
    check_eq("rx_ack_run",  32'(bus.rxlinkactiveack),   32'h1);
    check_eq("link_up",     32'(bus.link_up),           32'h1);
    check_eq("lane1_idle",  32'(bus.link_states[7:4]),  32'h0);

    // RX grants: exactly 15 with no flits, then one more after a flit.
    pulses = 0;
    for (int i = 0; i < 20; i++) begin
      if (bus.rx_lcrdv[0]) pulses++;
      tick();
    end
    check_eq("rx_grants15", 32'(pulses), 32'd15);
    check_eq("rx_grant_stop", 32'(bus.rx_lcrdv), 32'h0);
    bus.rx_flit_vld = 2'b01;
    tick();
    bus.rx_flit_vld = 2'b00;
    pulses = 0;
    for (int i = 0; i < 5; i++) begin
      if (bus.rx_lcrdv[0]) pulses++;
      tick();
    end
    check_eq("rx_regrant", 32'(pulses), 32'd1);

    // TX credits: 3 in, simultaneous in/out, single use.
    bus.tx_lcrdv = 2'b01;
    tick(3);
    check_eq("tx_cnt3", 32'(bus.tx_crd_cnt[3:0]), 32'd3);
    bus.tx_crd_use = 2'b01;
    tick();
    check_eq("tx_cnt_both", 32'(bus.tx_crd_cnt[3:0]), 32'd3);
    bus.tx_lcrdv = 2'b00;
    tick();
    check_eq("tx_cnt_use", 32'(bus.tx_crd_cnt[3:0]), 32'd2);
    bus.tx_crd_use = 2'b00;
    check_eq("no_err_yet", 32'(bus.err_crd), 32'h2);

    // Saturate at 15, then one more credit is an error.
    bus.tx_lcrdv = 2'b01;
    tick(13);
    check_eq("tx_cnt15", 32'(bus.tx_crd_cnt[3:0]), 32'd15);
    tick();
    bus.tx_lcrdv = 2'b00;
    check_eq("tx_sat_cnt", 32'(bus.tx_crd_cnt[3:0]), 32'd15);
    check_eq("tx_sat_err", 32'(bus.err_crd), 32'h3);

    // Use 12 down to 3 for teardown.
    bus.tx_crd_use = 2'b01;
    tick(12);
    bus.tx_crd_use = 2'b00;
    check_eq("tx_cnt_pre_td", 32'(bus.tx_crd_cnt[3:0]), 32'd3);

    // TX teardown with 3 credits held.
    bus.tx_up_req = 2'b00;
    tick();
    check_eq("tx_deact", 32'(bus.link_states[3:2]), 32'(TxDeact));
    check_eq("link_down", 32'(bus.link_up), 32'h0);
    pulses = 0;
    for (int i = 0; i < 4; i++) begin
      if (bus.tx_crd_return[0]) pulses++;
      tick();
    end
    check_eq("tx_returns", 32'(pulses), 32'd3);
    check_eq("tx_cnt0", 32'(bus.tx_crd_cnt[3:0]), 32'd0);
    check_eq("tx_hold_deact", 32'(bus.link_states[3:2]), 32'(TxDeact));
    bus.txlinkactiveack = 2'b00;
    tick();
    check_eq("tx_stop", 32'(bus.link_states[3:2]), 32'(TxStop));
    check_eq("tx_req_off", 32'(bus.txlinkactivereq), 32'h0);
    check_eq("no_tmo0", 32'(bus.err_timeout), 32'h0);

    // Timeout on lane 1: ack never arrives.
    bus.tx_up_req = 2'b10;
    tick();
    check_eq("tmo_act", 32'(bus.link_states[7:6]), 32'(TxAct));
    tick(7);
    check_eq("tmo_early", 32'(bus.err_timeout), 32'h0);
    tick();
    check_eq("tmo_set", 32'(bus.err_timeout), 32'h2);
    check_eq("tmo_state", 32'(bus.link_states[7:6]), 32'(TxAct));

    // Bring both lanes up with credits, then reset mid-Run.
    bus.tx_up_req       = 2'b11;
    bus.rxlinkactivereq = 2'b11;
    bus.rx_ready        = 2'b11;
    tick();
    bus.txlinkactiveack = 2'b11;
    tick();
    bus.tx_lcrdv = 2'b11;
    tick(2);
    bus.tx_lcrdv = 2'b00;
    check_eq("both_up", 32'(bus.link_up), 32'h3);
    check_eq("both_cnt", 32'(bus.tx_crd_cnt), 32'h22);
    ARESETn = 1'b0;
    tick();
    ARESETn = 1'b1;
    check_eq("mid_states", 32'(bus.link_states),     32'h0);
    check_eq("mid_txreq",  32'(bus.txlinkactivereq), 32'h0);
    check_eq("mid_rxack",  32'(bus.rxlinkactiveack), 32'h0);
    check_eq("mid_cnt",    32'(bus.tx_crd_cnt),      32'h0);
    check_eq("mid_misc",   32'({bus.rx_lcrdv, bus.tx_crd_return, bus.link_up}), 32'h0);
    check_eq("mid_errs",   32'({bus.err_timeout, bus.err_crd}), 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/chi5_link_ctrl.md
Name: chi5_link_ctrl

Overview:
- Parametrised, multi-link successor to the single-link CHI activation FSM.
- Each of NUM_LINKS lanes has an independent TX and RX link-activation state machine (Stop/Act/Run/Deact).
- Each lane also carries an L-credit counter pair and a handshake timeout monitor.
- Sits between the protocol layer (flit send/receive, credit use) and the physical link-activation wires of one CHI node.

Parameters:
- NUM_LINKS, 2: number of independent link lanes.
- TX_CRD_MAX, 15: maximum TX credits held per lane (saturation point).
- RX_CRD_MAX, 15: maximum RX credits granted per lane.
- TIMEOUT_CYCLES, 1024: cycles allowed in TxAct or TxDeact before timeout is flagged.

Ports:
- ACLK  in  1  clock
- ARESETn  in  1  synchronous active-low reset
- tx_up_req  in  NUM_LINKS  local request to bring the TX side up (level)
- txlinkactiveack  in  NUM_LINKS  remote acknowledge of TX activation
- txlinkactivereq  out  NUM_LINKS  TX activation request to remote
- tx_lcrdv  in  NUM_LINKS  one TX credit received from remote (pulse)
- tx_crd_use  in  NUM_LINKS  protocol layer consumes one TX credit (pulse)
- tx_crd_return  out  NUM_LINKS  one credit returned via LCrdReturn flit (pulse)
- tx_crd_cnt  out  NUM_LINKS*4  TX credits held, lane i at [4i+3:4i]
- rxlinkactivereq  in  NUM_LINKS  remote activation request
- rxlinkactiveack  out  NUM_LINKS  RX acknowledge to remote
- rx_ready  in  NUM_LINKS  local receiver ready to enter Run
- rx_flit_vld  in  NUM_LINKS  flit or LCrdReturn received; consumes one granted credit
- rx_lcrdv  out  NUM_LINKS  one RX credit granted to remote (pulse)
- link_states  out  NUM_LINKS*4  {tx_state[1:0], rx_state[1:0]} per lane
- link_up  out  NUM_LINKS  TX==Run and RX==Run
- err_timeout  out  NUM_LINKS  sticky handshake timeout
- err_crd  out  NUM_LINKS  sticky credit protocol error

Behaviour:
- Reset (ARESETn low at a posedge): all states go to Stop; all counters to 0; every output to 0. Reset mid-operation aborts any handshake with no credit return.
- All outputs are registered or decoded from registered state. A request/ack input is reflected on outputs one cycle after the sampling edge.
- TX FSM per lane, txlinkactivereq = (state==TxAct || state==TxRun):
  - TxStop -> TxAct when tx_up_req && !txlinkactiveack.
  - TxAct -> TxRun when txlinkactiveack.
  - TxRun -> TxDeact when !tx_up_req.
  - TxDeact -> TxStop when !txlinkactiveack && tx_crd_cnt==0.
- TX credits:
  - Increment on tx_lcrdv in TxAct or TxRun.
  - Decrement on tx_crd_use in TxRun only when count>0.
  - Increment and decrement in the same cycle leaves the count unchanged.
  - In TxDeact, tx_crd_return pulses once per cycle while count>0, decrementing the count.
  - Any of the following sets err_crd and leaves the count unchanged: tx_lcrdv at TX_CRD_MAX; tx_lcrdv in TxStop or TxDeact; tx_crd_use with count 0 or outside TxRun.
- RX FSM per lane:
  - RxStop -> RxAct when rxlinkactivereq.
  - RxAct -> RxRun when rx_ready.
  - RxRun -> RxDeact when !rxlinkactivereq.
  - RxDeact -> RxStop when rx_outstanding==0.
  - rxlinkactiveack = (state==RxRun || state==RxDeact).
  - If rxlinkactivereq drops in RxAct, the FSM still goes to RxRun, then to RxDeact on the next cycle.
- RX credits:
  - In RxRun, rx_lcrdv pulses each cycle while rx_outstanding<RX_CRD_MAX; each pulse increments rx_outstanding.
  - rx_flit_vld decrements rx_outstanding.
  - A grant and a flit in the same cycle leave rx_outstanding unchanged.
  - rx_flit_vld with rx_outstanding==0 sets err_crd.
  - No grants are issued in RxDeact.
- Timeout:
  - A per-lane counter of width $clog2(TIMEOUT_CYCLES+1) counts while TX is in TxAct or TxDeact, and clears on any other state.
  - When it reaches TIMEOUT_CYCLES, err_timeout is set and the counter holds. The FSM is unaffected.
- Error flags clear only on reset.
- Lanes are fully independent; no shared state.

Decomposition:
- Package chi5_link_ctrl_pkg holds:
  - typedef enum logic[1:0] {TxStop, TxAct, TxRun, TxDeact} tx_st_t;
  - typedef enum logic[1:0] {RxStop, RxAct, RxRun, RxDeact} rx_st_t;
  - packed struct lane_state_t {tx_st_t tx; rx_st_t rx;};
  - constant CRD_W=4.
- Sub-module chi5_link_lane implements one lane (both FSMs, credit counters, timeout). The top level generates NUM_LINKS instances.

Test Plan:
- Bring-up, lane 0: tx_up_req=1, ack=1 two cycles later, rxlinkactivereq=1, rx_ready=1 -> TX Stop->Act->Run. Then RX Stop->Act->Run, link_up[0]=1, lane 1 remains 0.
- RX grants: RxRun, no flits -> exactly 15 rx_lcrdv pulses, then none. One rx_flit_vld -> one further grant.
- TX teardown: TxRun with 3 credits, tx_up_req=0 -> TxDeact, 3 tx_crd_return pulses, count 0. After ack drops -> TxStop, txlinkactivereq=0.
- Timeout: TIMEOUT_CYCLES=8, tx_up_req=1, ack held 0 -> err_timeout high 8 cycles after TxAct entry, state stays TxAct.
- Credit errors: tx_lcrdv at count 15 -> err_crd=1, count stays 15. rx_flit_vld with outstanding 0 -> err_crd=1.
- Reset mid-Run (both lanes up, counts nonzero), ARESETn low one cycle -> all states Stop, all outputs 0 next cycle.
